// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Opcode, ALU-command and branch-type encodings, instruction
//               field positions and the decoded control bundle for id_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int c_reg_aw = 5;

    localparam int c_op_msb   = 31;
    localparam int c_op_lsb   = 26;
    localparam int c_dest_msb = 25;
    localparam int c_dest_lsb = 21;
    localparam int c_src1_msb = 20;
    localparam int c_src1_lsb = 16;
    localparam int c_src2_msb = 15;
    localparam int c_src2_lsb = 11;
    localparam int c_imm_msb  = 15;
    localparam int c_imm_lsb  = 0;

    localparam logic [5:0] c_op_nop  = 6'd0;
    localparam logic [5:0] c_op_add  = 6'd1;
    localparam logic [5:0] c_op_sub  = 6'd3;
    localparam logic [5:0] c_op_and  = 6'd5;
    localparam logic [5:0] c_op_or   = 6'd6;
    localparam logic [5:0] c_op_nor  = 6'd7;
    localparam logic [5:0] c_op_xor  = 6'd8;
    localparam logic [5:0] c_op_sla  = 6'd9;
    localparam logic [5:0] c_op_sll  = 6'd10;
    localparam logic [5:0] c_op_sra  = 6'd11;
    localparam logic [5:0] c_op_srl  = 6'd12;
    localparam logic [5:0] c_op_addi = 6'd32;
    localparam logic [5:0] c_op_subi = 6'd33;
    localparam logic [5:0] c_op_ld   = 6'd36;
    localparam logic [5:0] c_op_st   = 6'd37;
    localparam logic [5:0] c_op_bez  = 6'd40;
    localparam logic [5:0] c_op_bne  = 6'd41;
    localparam logic [5:0] c_op_jmp  = 6'd42;

    localparam logic [3:0] c_exe_add = 4'b0000;
    localparam logic [3:0] c_exe_sub = 4'b0010;
    localparam logic [3:0] c_exe_and = 4'b0100;
    localparam logic [3:0] c_exe_or  = 4'b0101;
    localparam logic [3:0] c_exe_nor = 4'b0110;
    localparam logic [3:0] c_exe_xor = 4'b0111;
    localparam logic [3:0] c_exe_shl = 4'b1000;
    localparam logic [3:0] c_exe_sra = 4'b1001;
    localparam logic [3:0] c_exe_srl = 4'b1010;

    localparam logic [1:0] c_br_none = 2'b00;
    localparam logic [1:0] c_br_bez  = 2'b01;
    localparam logic [1:0] c_br_bne  = 2'b10;
    localparam logic [1:0] c_br_jmp  = 2'b11;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic [1:0] br_type;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       imm_sel;
    } ctrl_t;

    function automatic logic is_rtype(input logic [5:0] op);
        return (op == c_op_add) || (op == c_op_sub) || (op == c_op_and) ||
               (op == c_op_or)  || (op == c_op_nor) || (op == c_op_xor) ||
               (op == c_op_sla) || (op == c_op_sll) || (op == c_op_sra) ||
               (op == c_op_srl);
    endfunction

    // Undefined opcodes fall through to the all-zero NOP bundle.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            c_op_add:  begin c.exe_cmd = c_exe_add; c.wb_en = 1'b1; end
            c_op_sub:  begin c.exe_cmd = c_exe_sub; c.wb_en = 1'b1; end
            c_op_and:  begin c.exe_cmd = c_exe_and; c.wb_en = 1'b1; end
            c_op_or:   begin c.exe_cmd = c_exe_or;  c.wb_en = 1'b1; end
            c_op_nor:  begin c.exe_cmd = c_exe_nor; c.wb_en = 1'b1; end
            c_op_xor:  begin c.exe_cmd = c_exe_xor; c.wb_en = 1'b1; end
            c_op_sla,
            c_op_sll:  begin c.exe_cmd = c_exe_shl; c.wb_en = 1'b1; end
            c_op_sra:  begin c.exe_cmd = c_exe_sra; c.wb_en = 1'b1; end
            c_op_srl:  begin c.exe_cmd = c_exe_srl; c.wb_en = 1'b1; end
            c_op_addi: begin c.exe_cmd = c_exe_add; c.wb_en = 1'b1; c.imm_sel = 1'b1; end
            c_op_subi: begin c.exe_cmd = c_exe_sub; c.wb_en = 1'b1; c.imm_sel = 1'b1; end
            c_op_ld:   begin c.wb_en = 1'b1; c.mem_r_en = 1'b1; c.imm_sel = 1'b1; end
            c_op_st:   begin c.mem_w_en = 1'b1; c.imm_sel = 1'b1; end
            c_op_bez:  begin c.br_type = c_br_bez; c.imm_sel = 1'b1; end
            c_op_bne:  begin c.br_type = c_br_bne; c.imm_sel = 1'b1; end
            c_op_jmp:  begin c.br_type = c_br_jmp; c.imm_sel = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic logic uses_src1(input logic [5:0] op);
        return is_rtype(op) || (op == c_op_addi) || (op == c_op_subi) ||
               (op == c_op_ld) || (op == c_op_st) || (op == c_op_bez) ||
               (op == c_op_bne);
    endfunction

    function automatic logic uses_src2(input logic [5:0] op);
        return is_rtype(op) || (op == c_op_st) || (op == c_op_bne);
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_register_file.sv
// ============================================================================
// Module      : register_file
// Description : Two async read ports, one sync write port with write-through;
//               R0 is hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file
    import mips_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_reg_aw-1:0] rd_addr1,
    input  logic [c_reg_aw-1:0] rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    input  logic                wr_en,
    input  logic [c_reg_aw-1:0] wr_addr,
    input  logic [DATA_W-1:0]   wr_data
);

    logic [DATA_W-1:0] r_regs [REG_COUNT];
    logic              w_wr_live;

    assign w_wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Write-through lets ID see a value WB is committing this same cycle.
    assign rd_data1 = (rd_addr1 == '0)                     ? '0      :
                      (w_wr_live && (wr_addr == rd_addr1)) ? wr_data :
                                                             r_regs[rd_addr1];
    assign rd_data2 = (rd_addr2 == '0)                     ? '0      :
                      (w_wr_live && (wr_addr == rd_addr2)) ? wr_data :
                                                             r_regs[rd_addr2];

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// Module      : id_stage
// Description : MIPS decode stage with register file, hazard detection and
//               the ID/EXE register. Define FORWARDING_EN for load-use-only
//               stalls and the src1_out/src2_out forwarding outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage
    import mips_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [31:0]       pc_in,
    input  logic              wb_en,
    input  logic [4:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic [4:0]        exe_dest,
    input  logic [4:0]        mem_dest,
    input  logic              exe_wb_en,
    input  logic              mem_wb_en,
    input  logic              exe_mem_r_en,
    input  logic              br_taken,
    output logic              hazard,
    output logic [3:0]        EXE_CMD,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic [DATA_W-1:0] val_src2,
    output logic [1:0]        Br_type,
    output logic [31:0]       PC,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [4:0]        dest
`ifdef FORWARDING_EN
    ,
    output logic [4:0]        src1_out,
    output logic [4:0]        src2_out
`endif
);

    logic [5:0]        w_opcode;
    logic [4:0]        w_dest_f;
    logic [4:0]        w_src1;
    logic [4:0]        w_src2;
    logic [4:0]        w_rd2_addr;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    ctrl_t             w_ctrl;
    logic              w_use1;
    logic              w_use2;
    logic              w_hazard;
    logic              w_bubble;

    assign w_opcode  = instruction[c_op_msb:c_op_lsb];
    assign w_dest_f  = instruction[c_dest_msb:c_dest_lsb];
    assign w_src1    = instruction[c_src1_msb:c_src1_lsb];
    assign w_src2    = instruction[c_src2_msb:c_src2_lsb];
    assign w_imm     = instruction[c_imm_msb:c_imm_lsb];
    assign w_imm_ext = {{(DATA_W-16){w_imm[15]}}, w_imm};
    assign w_ctrl    = decode_ctrl(w_opcode);

    // A store reads its data register through the dest field.
    assign w_rd2_addr = (w_opcode == c_op_st) ? w_dest_f : w_src2;

    register_file #(
        .REG_COUNT (REG_COUNT),
        .DATA_W    (DATA_W)
    ) u_register_file (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (w_src1),
        .rd_addr2 (w_rd2_addr),
        .rd_data1 (w_rd1),
        .rd_data2 (w_rd2),
        .wr_en    (wb_en),
        .wr_addr  (wb_dest),
        .wr_data  (wb_value)
    );

    assign w_use1 = uses_src1(w_opcode) && (w_src1 != '0);
    assign w_use2 = uses_src2(w_opcode) && (w_rd2_addr != '0);

`ifdef FORWARDING_EN
    logic w_unused_fwd;
    assign w_unused_fwd = ^{mem_dest, mem_wb_en};
    assign w_hazard = exe_mem_r_en && exe_wb_en &&
                      ((w_use1 && (w_src1 == exe_dest)) ||
                       (w_use2 && (w_rd2_addr == exe_dest)));
`else
    logic w_unused_fwd;
    assign w_unused_fwd = exe_mem_r_en;
    assign w_hazard = (exe_wb_en && ((w_use1 && (w_src1 == exe_dest)) ||
                                     (w_use2 && (w_rd2_addr == exe_dest)))) ||
                      (mem_wb_en && ((w_use1 && (w_src1 == mem_dest)) ||
                                     (w_use2 && (w_rd2_addr == mem_dest))));
`endif

    assign hazard   = w_hazard;
    assign w_bubble = br_taken || w_hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_bubble) begin
            EXE_CMD  <= '0;
            val1     <= '0;
            val2     <= '0;
            val_src2 <= '0;
            Br_type  <= '0;
            PC       <= '0;
            WB_EN    <= 1'b0;
            MEM_R_EN <= 1'b0;
            MEM_W_EN <= 1'b0;
            dest     <= '0;
`ifdef FORWARDING_EN
            src1_out <= '0;
            src2_out <= '0;
`endif
        end else begin
            EXE_CMD  <= w_ctrl.exe_cmd;
            val1     <= w_rd1;
            val2     <= w_ctrl.imm_sel ? w_imm_ext : w_rd2;
            val_src2 <= w_rd2;
            Br_type  <= w_ctrl.br_type;
            PC       <= pc_in;
            WB_EN    <= w_ctrl.wb_en;
            MEM_R_EN <= w_ctrl.mem_r_en;
            MEM_W_EN <= w_ctrl.mem_w_en;
            dest     <= w_dest_f;
`ifdef FORWARDING_EN
            src1_out <= w_src1;
            src2_out <= w_rd2_addr;
`endif
        end
    end

endmodule

`default_nettype wire
